// File: rtl/smc_pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state encoding
// and a timer-width helper sized from the longest interval the timer must count.
package smc_pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } sup_state_t;

    // The timer only ever counts to max_count-1, so clog2(max_count) bits suffice.
    function automatic int timer_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/smc_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to a
// parameterized value; general-purpose single-bit CDC cell.
module smc_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/smc_pll_lock_supervisor.sv
// PLL reset/lock sequencer on the reference clock. Define SMC_PLL_SUP_STATS_EN
// to implement the saturating lock-loss counter; otherwise lock_loss_cnt reads 0.
module smc_pll_lock_supervisor
    import smc_pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             sup_fail,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int TMR_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_MAX   = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES;
    localparam int TMR_W     = timer_width(TMR_MAX);
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam int STABLE_LAST = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0;

    sup_state_t         state, state_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [RETRY_W-1:0] retry_cnt, retry_n;
    logic               lk_s;
    logic               loss_inc;

    smc_sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    always_comb begin
        state_n  = state;
        timer_n  = timer + 1'b1;
        retry_n  = retry_cnt;
        loss_inc = 1'b0;
        case (state)
            RESET_PLL: begin
                if (timer == TMR_W'(RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    timer_n = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_n = STABLE;
                    timer_n = '0;
                end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    timer_n = '0;
                    retry_n = retry_cnt + 1'b1;
                    state_n = (retry_cnt == RETRY_W'(MAX_RETRIES - 1)) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_n = WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == TMR_W'(STABLE_LAST)) begin
                    state_n = RUN;
                    timer_n = '0;
                    retry_n = '0;
                end
            end
            RUN: begin
                timer_n = '0;
                if (!lk_s) begin
                    state_n  = RESET_PLL;
                    loss_inc = 1'b1;
                end
            end
            FAIL: begin
                timer_n = '0;
            end
            default: begin
                state_n = RESET_PLL;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= RESET_PLL;
            timer     <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            sup_fail  <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            retry_cnt <= retry_n;
            pll_rst   <= (state_n == RESET_PLL) || (state_n == FAIL);
            sys_rst   <= (state_n != RUN);
            sup_fail  <= (state_n == FAIL);
        end
    end

`ifdef SMC_PLL_SUP_STATS_EN
    logic [CNT_W-1:0] loss_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != {CNT_W{1'b1}})) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    logic unused_loss_inc;

    assign unused_loss_inc = loss_inc;
    assign lock_loss_cnt   = '0;
`endif

endmodule

// File: tb/tb_smc_pll_lock_supervisor.sv
// Randomized and directed bench for smc_pll_lock_supervisor against a
// cycle-level behavioural model of the supervision rules.
module tb_smc_pll_lock_supervisor;

    localparam int RST_C   = 4;
    localparam int TO_C    = 20;
    localparam int STAB_C  = 8;
    localparam int RETRY_C = 3;
    localparam int CNT_W   = 2;
    localparam int LOSS_MAX = (1 << CNT_W) - 1;

`ifdef SMC_PLL_SUP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic             refclk = 1'b0;
    logic             rst = 1'b0;
    logic             pll_locked = 1'b0;
    logic             pll_rst;
    logic             sys_rst;
    logic             sup_fail;
    logic [CNT_W-1:0] lock_loss_cnt;

    int vectors = 0;
    int miscompares = 0;

    // model of the supervisor, in terms of phases and elapsed cycles
    int   m_phase, m_spent, m_good, m_retries, m_losses;
    logic m_s1, m_s2;

    logic obs_pll_rst, obs_sys_rst, obs_sup_fail;
    int   obs_cnt;
    int   n, hi;

    smc_pll_lock_supervisor #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (STAB_C),
        .MAX_RETRIES   (RETRY_C),
        .CNT_W         (CNT_W)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .sup_fail      (sup_fail),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_phase   = P_RST;
        m_spent   = 0;
        m_good    = 0;
        m_retries = 0;
        m_losses  = 0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    task automatic modelStep(input logic v);
        logic lk;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = v;
        case (m_phase)
            P_RST: begin
                m_spent++;
                if (m_spent == RST_C) begin
                    m_phase = P_WAIT;
                    m_spent = 0;
                end
            end
            P_WAIT: begin
                if (lk) begin
                    m_phase = P_STAB;
                    m_good  = 1;
                end else begin
                    m_spent++;
                    if (m_spent == TO_C) begin
                        m_retries++;
                        m_spent = 0;
                        m_phase = (m_retries == RETRY_C) ? P_FAIL : P_RST;
                    end
                end
            end
            P_STAB: begin
                if (!lk) begin
                    m_phase = P_WAIT;
                    m_spent = 0;
                end else begin
                    m_good++;
                    if (m_good == STAB_C) begin
                        m_phase   = P_RUN;
                        m_retries = 0;
                    end
                end
            end
            P_RUN: begin
                if (!lk) begin
                    m_phase = P_RST;
                    m_spent = 0;
                    if (m_losses < LOSS_MAX) m_losses++;
                end
            end
            default: ;
        endcase
    endtask

    // Called at a negedge: drive, advance one edge, then compare on the next negedge.
    task automatic applyStimulus(input logic v);
        pll_locked = v;
        @(posedge refclk);
        modelStep(v);
        @(negedge refclk);
        obs_pll_rst  = pll_rst;
        obs_sys_rst  = sys_rst;
        obs_sup_fail = sup_fail;
        obs_cnt      = int'(lock_loss_cnt);
        checkOutput("pll_rst", obs_pll_rst, (m_phase == P_RST || m_phase == P_FAIL) ? 1 : 0);
        checkOutput("sys_rst", obs_sys_rst, (m_phase != P_RUN) ? 1 : 0);
        checkOutput("sup_fail", obs_sup_fail, (m_phase == P_FAIL) ? 1 : 0);
        checkOutput("lock_loss_cnt", obs_cnt, STATS ? m_losses : 0);
    endtask

    // Asserts rst between clock edges and expects outputs to react immediately.
    task automatic assertReset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        #1;
        checkOutput("rst_pll_rst", pll_rst, 1);
        checkOutput("rst_sys_rst", sys_rst, 1);
        checkOutput("rst_sup_fail", sup_fail, 0);
        checkOutput("rst_lock_loss_cnt", int'(lock_loss_cnt), 0);
        modelReset();
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        assertReset();

        // nominal lock
        n = 0;
        do begin applyStimulus(1'b0); n++; end while (obs_pll_rst && n < 50);
        checkOutput("nom_pll_rst_edges", n, RST_C);
        repeat (5) applyStimulus(1'b0);
        n = 0;
        do begin applyStimulus(1'b1); n++; end while (obs_sys_rst && n < 100);
        checkOutput("nom_release_latency", n, 2 + STAB_C);
        checkOutput("nom_loss_cnt", obs_cnt, 0);

        // lock loss from RUN
        n = 0;
        do begin applyStimulus(1'b0); n++; end while (!obs_sys_rst && n < 20);
        checkOutput("loss_sys_rst_latency", n, 3);
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            if (!obs_pll_rst) break;
            hi++;
        end
        checkOutput("loss_pll_rst_pulse", hi, RST_C);
        checkOutput("loss_cnt_one", obs_cnt, STATS ? 1 : 0);

        // one-cycle glitch at stable count 5 restarts the stable window
        repeat (2) applyStimulus(1'b0);
        repeat (5) applyStimulus(1'b1);
        applyStimulus(1'b0);
        n = 0;
        do begin applyStimulus(1'b1); n++; end while (obs_sys_rst && n < 100);
        checkOutput("glitch_release_latency", n, 2 + STAB_C);
        checkOutput("glitch_sup_fail", obs_sup_fail, 0);

        // randomized lock/unlock segments, including occasional timeouts
        for (int seg = 0; seg < 30; seg++) begin
            int   len;
            logic v;
            v = seg[0];
            if (v) len = $urandom_range(4, 30);
            else if ($urandom_range(0, 5) == 0) len = $urandom_range(22, 30);
            else len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) applyStimulus(v);
        end

        #2;
        assertReset();

        // never lock: three retry rounds then terminal failure
        n = 0;
        do begin applyStimulus(1'b0); n++; end while (!obs_sup_fail && n < 200);
        checkOutput("fail_edges", n, RETRY_C * (RST_C + TO_C));
        repeat (20) applyStimulus(1'($urandom_range(0, 1)));
        checkOutput("fail_pll_rst_held", obs_pll_rst, 1);
        checkOutput("fail_sup_fail_held", obs_sup_fail, 1);

        #2;
        assertReset();

        // five losses saturate a 2-bit counter, then reset mid-RUN
        for (int l = 0; l < 5; l++) begin
            n = 0;
            do begin applyStimulus(1'b1); n++; end while (obs_sys_rst && n < 200);
            checkOutput("sat_relock", (n < 200) ? 1 : 0, 1);
            repeat (6) applyStimulus(1'b0);
        end
        n = 0;
        do begin applyStimulus(1'b1); n++; end while (obs_sys_rst && n < 200);
        checkOutput("sat_in_run", obs_sys_rst, 0);
        checkOutput("sat_cnt", obs_cnt, STATS ? LOSS_MAX : 0);
        #2;
        assertReset();
        applyStimulus(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
